ofm_deskew_rf_16: RTL
=====================

Name: ofm_deskew_RF_16

Overview:
Output-side counterpart of the skewed IFM shift register files. It collects the 16 column results leaving the systolic array. Each column arrives one cycle later than the previous one, so the block realigns them into one output word per row. Aligned words are optionally rectified and buffered in a small FIFO, then drained to the OFM writer through a valid/ready handshake, with a per-tile row counter and a done pulse.

Parameters:
DATA_WIDTH, 8, bits per lane
BUFFER_COUNT, 16, number of lanes (array columns)
FIFO_DEPTH, 8, output FIFO entries (power of 2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous flush of delay lines, FIFO, counter and errors
size  input  5  active lane count; 0 or >16 treated as 16
row_total  input  8  rows per tile; 0 means 256
valid_in  input  BUFFER_COUNT  per-lane valid; bit i qualifies lane i
data_in  input  BUFFER_COUNT*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts the head word
out_data  output  BUFFER_COUNT*DATA_WIDTH  FIFO head word
done  output  1  one-cycle pulse on acceptance of the last row of a tile
overflow  output  1  sticky: aligned word dropped because the FIFO was full
skew_err  output  1  sticky: active lanes disagreed on aligned valid

Behaviour:
- Reset (rst high, async): all delay registers, FIFO pointers and count, row counter, out_valid, done, overflow and skew_err go to 0. out_data reads 0.
- clear has the same effect as reset, but synchronous. clear takes priority over every other event in that cycle.
- Deskew:
  - Lane i passes data and valid through a delay of (BUFFER_COUNT-1-i) registers. Lane 15 has zero delay (wire). Lane 0 has 15 registers.
  - Input contract: a row's lane i value is presented at cycle t0+i. All lanes are aligned at the deskew output in cycle t0+15.
- Masking: lanes i >= effective size are forced to 0 at the deskew output, and their valid bits are ignored.
- Aligned valid is lane 0's delayed valid.
  - If any active lane's delayed valid differs from lane 0's in a cycle, set skew_err.
  - The word is still written, gated by lane 0's valid.
- FIFO write:
  - Write the aligned word when aligned valid is high AND (count < FIFO_DEPTH OR a read occurs in the same cycle).
  - Otherwise drop the word and set overflow.
- FIFO read: occurs when out_valid && out_ready.
  - out_valid = (count != 0).
  - out_data shows the head entry (first-word fall-through from a registered array).
- Latency: with the FIFO empty, a row whose lane 0 enters at t0 is presented on out_valid/out_data at cycle t0+16.
- Throughput: one row per cycle sustained when out_ready is held high.
- Simultaneous read and write: count is unchanged, at both full and empty. When count=0, the written word becomes visible the next cycle; there is no same-cycle bypass.
- Row counter:
  - Increments on each read.
  - On the read that brings it to row_total (256 when row_total is 0), done pulses for 1 cycle and the counter returns to 0.
  - row_total is sampled on every read; change it only between tiles.
- overflow and skew_err stay set until rst or clear.

Optional Feature:
OFM_RELU_EN
- Defined: each active lane is treated as signed two's complement, and a negative value is replaced by 0 before the FIFO write. Masked lanes stay 0.
- Undefined: lanes pass through unmodified.
- Latency is identical either way.

Decomposition:
- Shared package ofm_pkg:
  - DATA_WIDTH and BUFFER_COUNT defaults.
  - Function eff_size(size) returning 1..16.
  - Function lane_mask(size) returning a BUFFER_COUNT-bit active mask.
- Sub-module ofm_delay_line:
  - Parameters DATA_WIDTH and LENGTH; LENGTH=0 elaborates as a wire.
  - Carries {valid, data}.
  - Instantiated 16 times with LENGTH = BUFFER_COUNT-1-i.
- FIFO and row counter are inline in the top.

Test Plan:
- Skewed rows: size=16, row_total=4, out_ready=1; rows 1..4 with lane i=row*16+i, lane i driven at t0+i → four aligned words, first one at t0+16, lanes in order; done pulses with the 4th accept.
- Masking: size=5, all lanes driven with 0x7F → out_data lanes 0..4 = 0x7F, lanes 5..15 = 0, skew_err stays 0 even when lanes 5..15 carry bad valids.
- Backpressure: out_ready=0, 10 consecutive rows → 8 words buffered, overflow=1 at the 9th. Then out_ready=1 → exactly rows 1..8 drained in order.
- Full plus simultaneous read: fill to 8, then out_ready=1 while rows keep arriving → no overflow, count stays 8, order preserved.
- Skew fault: lane 3 valid asserted one cycle late → skew_err=1; clear → skew_err=0, out_valid=0, counter 0.
- Reset mid-stream and ReLU: assert rst with 3 words buffered → out_valid=0 immediately. With OFM_RELU_EN defined, lane value 0x80 → 0x00 and 0x05 → 0x05; without it, 0x80 passes through.

Source files
------------

// File: rtl/ofm_pkg.sv
// Shared defaults and lane-size helpers for the OFM deskew block.
// Consumers: ofm_delay_line, ofm_deskew_rf_16.
package ofm_pkg;

  localparam int OFM_DATA_WIDTH   = 8;
  localparam int OFM_BUFFER_COUNT = 16;

  // 0 or anything above the lane count means "all lanes"
  function automatic logic [4:0] eff_size(input logic [4:0] size);
    if (size == 5'd0 || size > 5'd16)
      return 5'd16;
    return size;
  endfunction

  function automatic logic [OFM_BUFFER_COUNT-1:0] lane_mask(
    input logic [4:0] size
  );
    logic [OFM_BUFFER_COUNT-1:0] m;
    logic [4:0]                  n;
    n = eff_size(size);
    for (int i = 0; i < OFM_BUFFER_COUNT; i++)
      m[i] = (i < int'(n));
    return m;
  endfunction

endpackage

// File: rtl/ofm_delay_line.sv
// Fixed-length {valid, data} delay line for one deskew lane.
// LENGTH=0 collapses to a plain wire.
module ofm_delay_line
  import ofm_pkg::*;
#(
  parameter int DATA_WIDTH = OFM_DATA_WIDTH,
  parameter int LENGTH     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  generate
    if (LENGTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk ^ rst ^ clear;
      assign o_valid  = i_valid;
      assign o_data   = i_data;
    end else begin : g_reg
      logic [DATA_WIDTH:0] r_pipe [LENGTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LENGTH; i++)
            r_pipe[i] <= '0;
        end else if (clear) begin
          for (int i = 0; i < LENGTH; i++)
            r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= {i_valid, i_data};
          for (int i = 1; i < LENGTH; i++)
            r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_valid = r_pipe[LENGTH-1][DATA_WIDTH];
      assign o_data  = r_pipe[LENGTH-1][DATA_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/ofm_deskew_rf_16.sv
// Realigns skewed systolic column outputs into rows, then FIFOs them out.
// Optional macro OFM_RELU_EN clamps negative active lanes to zero.
module ofm_deskew_rf_16
  import ofm_pkg::*;
#(
  parameter int DATA_WIDTH   = OFM_DATA_WIDTH,
  parameter int BUFFER_COUNT = OFM_BUFFER_COUNT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic [4:0]                         size,
  input  logic [7:0]                         row_total,
  input  logic [BUFFER_COUNT-1:0]            valid_in,
  input  logic [BUFFER_COUNT*DATA_WIDTH-1:0] data_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [BUFFER_COUNT*DATA_WIDTH-1:0] out_data,
  output logic                               done,
  output logic                               overflow,
  output logic                               skew_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = BUFFER_COUNT * DATA_WIDTH;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [BUFFER_COUNT-1:0] w_mask;
  logic [BUFFER_COUNT-1:0] w_dv;
  logic [DATA_WIDTH-1:0]   w_dd [BUFFER_COUNT];
  logic [LW-1:0]           w_word;

  assign w_mask = lane_mask(size);

  // lane i waits BUFFER_COUNT-1-i cycles so every lane lands with lane 0
  generate
    for (genvar i = 0; i < BUFFER_COUNT; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] w_lane;

      ofm_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .LENGTH     (BUFFER_COUNT-1-i)
      ) u_dl (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .i_valid (valid_in[i]),
        .i_data  (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
        .o_valid (w_dv[i]),
        .o_data  (w_dd[i])
      );

      always_comb begin
        w_lane = w_mask[i] ? w_dd[i] : '0;
`ifdef OFM_RELU_EN
        if (w_lane[DATA_WIDTH-1])
          w_lane = '0;
`endif
      end

      assign w_word[i*DATA_WIDTH +: DATA_WIDTH] = w_lane;
    end
  endgenerate

  logic          w_aval;
  logic          w_skew;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic          w_drop;
  logic [8:0]    w_total;
  logic [8:0]    w_row_nxt;
  logic          w_last;

  logic [LW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [8:0]    r_row;
  logic          r_ovf;
  logic          r_skew;

  assign w_aval = w_dv[0];
  assign w_skew =
    |((w_dv ^ {BUFFER_COUNT{w_dv[0]}}) & w_mask);

  assign w_full = (r_count == DEPTH_C);
  assign w_rd   = (r_count != '0) & out_ready & ~clear;
  assign w_wr   = w_aval & ~clear & (~w_full | w_rd);
  assign w_drop = w_aval & ~clear & w_full & ~w_rd;

  assign w_total   = (row_total == 8'd0) ? 9'd256
                                         : {1'b0, row_total};
  assign w_row_nxt = r_row + 9'd1;
  assign w_last    = w_rd & (w_row_nxt == w_total);

  // storage carries no reset; the head is gated by count below
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_row   <= '0;
      r_ovf   <= 1'b0;
      r_skew  <= 1'b0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_row   <= '0;
      r_ovf   <= 1'b0;
      r_skew  <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + AW'(1);
      if (w_rd)
        r_rptr <= r_rptr + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_rd)
        r_row <= w_last ? 9'd0 : w_row_nxt;
      if (w_drop)
        r_ovf <= 1'b1;
      if (w_skew)
        r_skew <= 1'b1;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rptr] : '0;
  assign done      = w_last;
  assign overflow  = r_ovf;
  assign skew_err  = r_skew;

endmodule
